wishbone_bus_if: RTL and testbench
==================================

Name: wishbone_bus_if

Overview:
- Bus-master bridge between a CPU pipeline memory port (instruction fetch or MEM-stage data access) and a Wishbone B3 classic single-cycle-transfer bus.
- Accepts a request from the CPU side, runs one Wishbone read or write, and holds the pipeline through a stall request until the transfer completes.
- Respects the pipeline stall and flush vectors so a response is never lost or duplicated.
- Two instances are used: one per memory port.

Parameters:
- AW, 32, address width
- DW, 32, data width (byte lanes = DW/8)

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- stall  in  6  pipeline stall vector; bit set means that stage is held
- flush  in  1  pipeline flush (exception); aborts any transfer in progress
- cpu_ce_i  in  1  CPU request valid, held while the request is pending
- cpu_addr_i  in  AW  request address
- cpu_data_i  in  DW  write data
- cpu_we_i  in  1  1 = write, 0 = read
- cpu_sel_i  in  DW/8  byte-lane select
- cpu_data_o  out  DW  read data returned to the CPU
- stallreq  out  1  request to the pipeline controller to stall
- wb_addr_o  out  AW  Wishbone address
- wb_data_o  out  DW  Wishbone write data
- wb_we_o  out  1  Wishbone write enable
- wb_sel_o  out  DW/8  Wishbone byte select
- wb_stb_o  out  1  Wishbone strobe
- wb_cyc_o  out  1  Wishbone cycle
- wb_data_i  in  DW  Wishbone read data
- wb_ack_i  in  1  Wishbone acknowledge

Behaviour:
- Registered outputs: wb_* and the internal read buffer rd_buf. Combinational outputs: stallreq and cpu_data_o, derived from state and inputs.
- Reset, or flush in any state, sets registers to: state=IDLE; wb_addr_o, wb_data_o, wb_we_o, wb_sel_o, wb_stb_o, wb_cyc_o and rd_buf all 0. Reset takes priority over everything. Reset mid-transfer drops the cycle immediately.
- IDLE:
  - If cpu_ce_i=1 and flush=0, on the next clk drive wb_stb_o=wb_cyc_o=1 and latch wb_addr_o, wb_data_o, wb_we_o, wb_sel_o from the cpu_* inputs; go to BUSY.
  - Otherwise stay in IDLE.
- BUSY:
  - With wb_ack_i=1 and flush=0, on the next clk:
    - Clear wb_stb_o, wb_cyc_o, wb_we_o, wb_sel_o, wb_addr_o and wb_data_o.
    - If wb_we_o=0, set rd_buf <= wb_data_i.
    - Go to WAIT_FOR_STALL if stall != 0, else IDLE.
  - With wb_ack_i=0, hold all Wishbone outputs stable, as Wishbone requires.
  - Flush while in BUSY aborts: cycle dropped, go to IDLE, rd_buf=0. A late ack is ignored.
- WAIT_FOR_STALL: the pipeline is held by another stage. Stay here while stall != 0 and go to IDLE when stall == 0. rd_buf is held.
- stallreq:
  - IDLE: 1 when cpu_ce_i=1 and flush=0, else 0.
  - BUSY: 0 in the cycle wb_ack_i=1, else 1.
  - WAIT_FOR_STALL: 0.
  - flush=1 forces 0.
- cpu_data_o:
  - IDLE: 0.
  - BUSY: wb_data_i when wb_ack_i=1 and the access is a read, else 0.
  - WAIT_FOR_STALL: rd_buf.
- Latency:
  - Minimum 2 clk from cpu_ce_i assert to the data cycle: 1 cycle to launch, plus a wait for ack.
  - Zero-wait slave: ack is seen in the first BUSY cycle, so stallreq is high exactly 1 cycle.
- Back-to-back requests: returning to IDLE with cpu_ce_i still high launches a new transfer the next clk. The CPU side is responsible for changing or deasserting the request once stallreq drops.
- A write completes identically. cpu_data_o stays 0 and rd_buf is unchanged.

Test Plan:
- Zero-wait read:
  - Stimulus: cpu_ce_i=1, we=0, addr=0x00000100, sel=0xF; slave acks in the first BUSY cycle with 0xDEADBEEF.
  - Required response: cyc/stb high 1 cycle; stallreq high 1 cycle then low; cpu_data_o=0xDEADBEEF in the ack cycle; state returns to IDLE.
- 3-wait-state write:
  - Stimulus: addr=0x00000204, data=0x12345678, sel=0x3; ack in the 4th BUSY cycle.
  - Required response: wb_* outputs stable for 4 cycles; stallreq=1 for 4 cycles, including the launch cycle; cpu_data_o stays 0.
- Read completing under an external stall:
  - Stimulus: stall=6'b000111 during the ack cycle, read data 0xA5A5A5A5.
  - Required response: enter WAIT_FOR_STALL; cpu_data_o=0xA5A5A5A5 held while stall != 0; IDLE the cycle after stall=0.
- Flush mid-transfer:
  - Stimulus: flush=1 in the 2nd BUSY cycle, followed by a later ack.
  - Required response: stb/cyc drop on the next clk; state=IDLE; stallreq=0; the late ack produces no cpu_data_o change.
- Synchronous reset in BUSY:
  - Stimulus: rst=1 in BUSY.
  - Required response: next clk all wb_* outputs=0, state=IDLE, rd_buf=0.
- Back-to-back reads:
  - Stimulus: two consecutive reads, 0x10 and 0x14, zero-wait slave.
  - Required response: the second cyc asserts 1 clk after the first ack; each cpu_data_o is correct.

Source files
------------

// File: rtl/wishbone_bus_if_if.sv
// Wishbone B3 classic bus signals between the CPU-side bridge (master) and a slave.
interface wishbone_bus_if_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic [AW-1:0]   wb_addr_o;
  logic [DW-1:0]   wb_data_o;
  logic            wb_we_o;
  logic [DW/8-1:0] wb_sel_o;
  logic            wb_stb_o;
  logic            wb_cyc_o;
  logic [DW-1:0]   wb_data_i;
  logic            wb_ack_i;

  modport master (
    output wb_addr_o, wb_data_o, wb_we_o, wb_sel_o, wb_stb_o, wb_cyc_o,
    input  wb_data_i, wb_ack_i
  );

  modport slave (
    input  wb_addr_o, wb_data_o, wb_we_o, wb_sel_o, wb_stb_o, wb_cyc_o,
    output wb_data_i, wb_ack_i
  );
endinterface

// File: rtl/wishbone_bus_if.sv
// CPU memory-port to Wishbone classic bridge: one single transfer per request,
// stalling the pipeline until ack and buffering read data while the pipeline is held.
module wishbone_bus_if #(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [5:0]      stall,
  input  logic            flush,
  input  logic            cpu_ce_i,
  input  logic [AW-1:0]   cpu_addr_i,
  input  logic [DW-1:0]   cpu_data_i,
  input  logic            cpu_we_i,
  input  logic [DW/8-1:0] cpu_sel_i,
  output logic [DW-1:0]   cpu_data_o,
  output logic            stallreq,
  wishbone_bus_if_if.master wb
);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    WAIT_FOR_STALL
  } state_t;

  state_t          state, state_nx;
  logic [AW-1:0]   addr_q, addr_nx;
  logic [DW-1:0]   wdata_q, wdata_nx;
  logic            we_q, we_nx;
  logic [DW/8-1:0] sel_q, sel_nx;
  logic            stb_q, stb_nx;
  logic            cyc_q, cyc_nx;
  logic [DW-1:0]   rd_buf, rd_buf_nx;

  // NOTE: every signal written here gets a default first, so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    state_nx   = state;
    addr_nx    = addr_q;
    wdata_nx   = wdata_q;
    we_nx      = we_q;
    sel_nx     = sel_q;
    stb_nx     = stb_q;
    cyc_nx     = cyc_q;
    rd_buf_nx  = rd_buf;
    stallreq   = 1'b0;
    cpu_data_o = '0;

    case (state)
      IDLE: begin
        if (cpu_ce_i) begin
          state_nx = BUSY;
          addr_nx  = cpu_addr_i;
          wdata_nx = cpu_data_i;
          we_nx    = cpu_we_i;
          sel_nx   = cpu_sel_i;
          stb_nx   = 1'b1;
          cyc_nx   = 1'b1;
          stallreq = 1'b1;
        end
      end

      BUSY: begin
        if (wb.wb_ack_i) begin
          addr_nx  = '0;
          wdata_nx = '0;
          we_nx    = 1'b0;
          sel_nx   = '0;
          stb_nx   = 1'b0;
          cyc_nx   = 1'b0;
          if (!we_q) begin
            rd_buf_nx  = wb.wb_data_i;
            cpu_data_o = wb.wb_data_i;
          end
          // Another stage still holds the pipeline: park the read data until it moves.
          state_nx = (stall != '0) ? WAIT_FOR_STALL : IDLE;
        end else begin
          stallreq = 1'b1;
        end
      end

      WAIT_FOR_STALL: begin
        cpu_data_o = rd_buf;
        if (stall == '0) state_nx = IDLE;
      end

      default: state_nx = IDLE;
    endcase

    // An exception abandons whatever is in flight; a late ack then finds cyc low.
    if (flush) begin
      state_nx  = IDLE;
      addr_nx   = '0;
      wdata_nx  = '0;
      we_nx     = 1'b0;
      sel_nx    = '0;
      stb_nx    = 1'b0;
      cyc_nx    = 1'b0;
      rd_buf_nx = '0;
      stallreq  = 1'b0;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      sel_q   <= '0;
      stb_q   <= 1'b0;
      cyc_q   <= 1'b0;
      rd_buf  <= '0;
    end else begin
      state   <= state_nx;
      addr_q  <= addr_nx;
      wdata_q <= wdata_nx;
      we_q    <= we_nx;
      sel_q   <= sel_nx;
      stb_q   <= stb_nx;
      cyc_q   <= cyc_nx;
      rd_buf  <= rd_buf_nx;
    end
  end

  assign wb.wb_addr_o = addr_q;
  assign wb.wb_data_o = wdata_q;
  assign wb.wb_we_o   = we_q;
  assign wb.wb_sel_o  = sel_q;
  assign wb.wb_stb_o  = stb_q;
  assign wb.wb_cyc_o  = cyc_q;

endmodule

// File: tb/tb_wishbone_bus_if.sv
// Scenario bench for wishbone_bus_if: tasks drive the CPU port and a scripted slave;
// a scoreboard of launched transfers is checked whenever the bus acknowledges.
module tb_wishbone_bus_if;
  localparam int AW = 32;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic [5:0]    stall;
  logic          flush;
  logic          cpu_ce_i;
  logic [31:0]   cpu_addr_i;
  logic [31:0]   cpu_data_i;
  logic          cpu_we_i;
  logic [3:0]    cpu_sel_i;
  logic [31:0]   cpu_data_o;
  logic          stallreq;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        we;
    logic [3:0]  sel;
  } txn_t;

  txn_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  wishbone_bus_if_if #(.AW(AW), .DW(DW)) bus ();

  wishbone_bus_if #(.AW(AW), .DW(DW)) dut (
    .clk        (clk),
    .rst        (rst),
    .stall      (stall),
    .flush      (flush),
    .cpu_ce_i   (cpu_ce_i),
    .cpu_addr_i (cpu_addr_i),
    .cpu_data_i (cpu_data_i),
    .cpu_we_i   (cpu_we_i),
    .cpu_sel_i  (cpu_sel_i),
    .cpu_data_o (cpu_data_o),
    .stallreq   (stallreq),
    .wb         (bus)
  );

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  // Present a request on the CPU port; score it only if it is expected to complete.
  task automatic request(input logic [31:0] addr, input logic [31:0] wdata, input logic we,
                         input logic [3:0] sel, input logic [31:0] rdata, input bit score);
    txn_t t;
    cpu_ce_i   = 1'b1;
    cpu_addr_i = addr;
    cpu_data_i = wdata;
    cpu_we_i   = we;
    cpu_sel_i  = sel;
    t.addr = addr; t.wdata = wdata; t.rdata = rdata; t.we = we; t.sel = sel;
    if (score) sb_q.push_back(t);
  endtask

  // Scoreboard: every acknowledged cycle must match the oldest launched request.
  always @(negedge clk) begin
    txn_t t;
    if (!rst && !flush && bus.wb_cyc_o && bus.wb_ack_i) begin
      checks++;
      if (sb_q.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected_ack: ack seen at addr %h with no request expected", bus.wb_addr_o);
      end else begin
        t = sb_q.pop_front();
        if ({bus.wb_addr_o, bus.wb_we_o, bus.wb_sel_o} !== {t.addr, t.we, t.sel}) begin
          errors++;
          $display("FAIL sb_bus_fields: got addr=%h we=%b sel=%h expected addr=%h we=%b sel=%h",
                   bus.wb_addr_o, bus.wb_we_o, bus.wb_sel_o, t.addr, t.we, t.sel);
        end
        checks++;
        if (cpu_data_o !== (t.we ? 32'h0 : t.rdata)) begin
          errors++;
          $display("FAIL sb_cpu_data: got %h expected %h", cpu_data_o, (t.we ? 32'h0 : t.rdata));
        end
        if (t.we) begin
          checks++;
          if (bus.wb_data_o !== t.wdata) begin
            errors++;
            $display("FAIL sb_wdata: got %h expected %h", bus.wb_data_o, t.wdata);
          end
        end
      end
    end
  end

  task automatic test_reset();
    rst = 1'b1; stall = '0; flush = 1'b0;
    cpu_ce_i = 1'b0; cpu_addr_i = '0; cpu_data_i = '0; cpu_we_i = 1'b0; cpu_sel_i = '0;
    bus.wb_ack_i = 1'b0; bus.wb_data_i = '0;
    next_cycle();
    next_cycle();
    sample();
    checks++;
    if ({bus.wb_cyc_o, bus.wb_stb_o, bus.wb_we_o, bus.wb_sel_o, bus.wb_addr_o, bus.wb_data_o} !== '0) begin
      errors++;
      $display("FAIL reset_wb: got cyc=%b stb=%b we=%b sel=%h addr=%h data=%h expected all 0",
               bus.wb_cyc_o, bus.wb_stb_o, bus.wb_we_o, bus.wb_sel_o, bus.wb_addr_o, bus.wb_data_o);
    end
    checks++;
    if ({stallreq, cpu_data_o} !== 33'h0) begin
      errors++;
      $display("FAIL reset_cpu: got stallreq=%b data=%h expected 0 0", stallreq, cpu_data_o);
    end
    next_cycle();
    rst = 1'b0;
  endtask

  task automatic test_zero_wait_read();
    next_cycle();
    request(32'h0000_0100, 32'h0, 1'b0, 4'hF, 32'hDEAD_BEEF, 1'b1);
    sample();
    checks++;
    if ({stallreq, bus.wb_cyc_o} !== 2'b10) begin
      errors++;
      $display("FAIL zw_launch: got stallreq=%b cyc=%b expected 1 0", stallreq, bus.wb_cyc_o);
    end
    next_cycle();
    bus.wb_ack_i = 1'b1; bus.wb_data_i = 32'hDEAD_BEEF;
    sample();
    checks++;
    if ({bus.wb_cyc_o, bus.wb_stb_o, stallreq} !== 3'b110) begin
      errors++;
      $display("FAIL zw_ack_cycle: got cyc=%b stb=%b stallreq=%b expected 1 1 0",
               bus.wb_cyc_o, bus.wb_stb_o, stallreq);
    end
    next_cycle();
    bus.wb_ack_i = 1'b0; bus.wb_data_i = '0; cpu_ce_i = 1'b0;
    sample();
    checks++;
    if ({bus.wb_cyc_o, bus.wb_stb_o, stallreq, cpu_data_o} !== 35'h0) begin
      errors++;
      $display("FAIL zw_idle: got cyc=%b stb=%b stallreq=%b data=%h expected 0 0 0 0",
               bus.wb_cyc_o, bus.wb_stb_o, stallreq, cpu_data_o);
    end
  endtask

  task automatic test_wait_write();
    next_cycle();
    request(32'h0000_0204, 32'h1234_5678, 1'b1, 4'h3, 32'h0, 1'b1);
    sample();
    checks++;
    if (stallreq !== 1'b1) begin
      errors++;
      $display("FAIL ww_launch_stallreq: got %b expected 1", stallreq);
    end
    for (int i = 0; i < 4; i++) begin
      next_cycle();
      if (i == 3) bus.wb_ack_i = 1'b1;
      sample();
      checks++;
      if ({bus.wb_cyc_o, bus.wb_stb_o, bus.wb_we_o, bus.wb_sel_o, bus.wb_addr_o, bus.wb_data_o}
          !== {3'b111, 4'h3, 32'h0000_0204, 32'h1234_5678}) begin
        errors++;
        $display("FAIL ww_stable_%0d: got cyc=%b stb=%b we=%b sel=%h addr=%h data=%h expected 1 1 1 3 00000204 12345678",
                 i, bus.wb_cyc_o, bus.wb_stb_o, bus.wb_we_o, bus.wb_sel_o, bus.wb_addr_o, bus.wb_data_o);
      end
      checks++;
      if ({stallreq, cpu_data_o} !== {(i < 3), 32'h0}) begin
        errors++;
        $display("FAIL ww_stall_%0d: got stallreq=%b data=%h expected %b 0", i, stallreq, cpu_data_o, (i < 3));
      end
    end
    next_cycle();
    bus.wb_ack_i = 1'b0; cpu_ce_i = 1'b0; cpu_we_i = 1'b0;
    sample();
    checks++;
    if ({bus.wb_cyc_o, bus.wb_we_o, bus.wb_sel_o, bus.wb_addr_o} !== '0) begin
      errors++;
      $display("FAIL ww_cleared: got cyc=%b we=%b sel=%h addr=%h expected all 0",
               bus.wb_cyc_o, bus.wb_we_o, bus.wb_sel_o, bus.wb_addr_o);
    end
  endtask

  task automatic test_stall_read();
    next_cycle();
    request(32'h0000_0300, 32'h0, 1'b0, 4'hF, 32'hA5A5_A5A5, 1'b1);
    sample();
    next_cycle();
    bus.wb_ack_i = 1'b1; bus.wb_data_i = 32'hA5A5_A5A5; stall = 6'b000111;
    sample();
    checks++;
    if (stallreq !== 1'b0) begin
      errors++;
      $display("FAIL st_ack_stallreq: got %b expected 0", stallreq);
    end
    // Slave data is removed, so only the internal buffer can supply the value.
    for (int i = 0; i < 3; i++) begin
      next_cycle();
      bus.wb_ack_i = 1'b0; bus.wb_data_i = '0; cpu_ce_i = 1'b0;
      if (i == 2) stall = '0;
      sample();
      checks++;
      if ({cpu_data_o, stallreq, bus.wb_cyc_o} !== {32'hA5A5_A5A5, 2'b00}) begin
        errors++;
        $display("FAIL st_hold_%0d: got data=%h stallreq=%b cyc=%b expected a5a5a5a5 0 0",
                 i, cpu_data_o, stallreq, bus.wb_cyc_o);
      end
    end
    next_cycle();
    sample();
    checks++;
    if (cpu_data_o !== 32'h0) begin
      errors++;
      $display("FAIL st_back_to_idle: got data=%h expected 0", cpu_data_o);
    end
  endtask

  task automatic test_reset_in_busy();
    next_cycle();
    request(32'h0000_0400, 32'hCAFE_F00D, 1'b1, 4'hF, 32'h0, 1'b0);
    sample();
    next_cycle();
    rst = 1'b1;
    sample();
    checks++;
    if (bus.wb_cyc_o !== 1'b1) begin
      errors++;
      $display("FAIL rb_busy_before_edge: got cyc=%b expected 1", bus.wb_cyc_o);
    end
    next_cycle();
    rst = 1'b0; cpu_ce_i = 1'b0; cpu_we_i = 1'b0;
    sample();
    checks++;
    if ({bus.wb_cyc_o, bus.wb_stb_o, bus.wb_we_o, bus.wb_sel_o, bus.wb_addr_o, bus.wb_data_o, stallreq} !== '0) begin
      errors++;
      $display("FAIL rb_dropped: got cyc=%b stb=%b we=%b sel=%h addr=%h data=%h stallreq=%b expected all 0",
               bus.wb_cyc_o, bus.wb_stb_o, bus.wb_we_o, bus.wb_sel_o, bus.wb_addr_o, bus.wb_data_o, stallreq);
    end
    // A write finishing under stall exposes the read buffer, which reset must have cleared.
    next_cycle();
    request(32'h0000_0404, 32'h0000_0001, 1'b1, 4'h1, 32'h0, 1'b1);
    sample();
    next_cycle();
    bus.wb_ack_i = 1'b1; stall = 6'b000001;
    sample();
    next_cycle();
    bus.wb_ack_i = 1'b0; cpu_ce_i = 1'b0; cpu_we_i = 1'b0;
    sample();
    checks++;
    if ({cpu_data_o, stallreq} !== 33'h0) begin
      errors++;
      $display("FAIL rb_rd_buf_cleared: got data=%h stallreq=%b expected 0 0", cpu_data_o, stallreq);
    end
    next_cycle();
    stall = '0;
    sample();
  endtask

  task automatic test_flush();
    next_cycle();
    request(32'h0000_0500, 32'h0, 1'b0, 4'hF, 32'h1111_1111, 1'b0);
    sample();
    next_cycle();
    sample();
    checks++;
    if ({stallreq, bus.wb_cyc_o} !== 2'b11) begin
      errors++;
      $display("FAIL fl_busy1: got stallreq=%b cyc=%b expected 1 1", stallreq, bus.wb_cyc_o);
    end
    next_cycle();
    flush = 1'b1;
    sample();
    checks++;
    if (stallreq !== 1'b0) begin
      errors++;
      $display("FAIL fl_stallreq: got %b expected 0", stallreq);
    end
    next_cycle();
    flush = 1'b0; cpu_ce_i = 1'b0; bus.wb_ack_i = 1'b1; bus.wb_data_i = 32'h1111_1111;
    sample();
    checks++;
    if ({bus.wb_cyc_o, bus.wb_stb_o, stallreq, cpu_data_o} !== 35'h0) begin
      errors++;
      $display("FAIL fl_late_ack: got cyc=%b stb=%b stallreq=%b data=%h expected 0 0 0 0",
               bus.wb_cyc_o, bus.wb_stb_o, stallreq, cpu_data_o);
    end
    next_cycle();
    bus.wb_ack_i = 1'b0; bus.wb_data_i = '0;
    sample();
    checks++;
    if (cpu_data_o !== 32'h0) begin
      errors++;
      $display("FAIL fl_after: got data=%h expected 0", cpu_data_o);
    end
  endtask

  task automatic test_back_to_back();
    next_cycle();
    request(32'h0000_0010, 32'h0, 1'b0, 4'hF, 32'h0102_0304, 1'b1);
    sample();
    next_cycle();
    bus.wb_ack_i = 1'b1; bus.wb_data_i = 32'h0102_0304;
    sample();
    next_cycle();
    bus.wb_ack_i = 1'b0; bus.wb_data_i = '0;
    request(32'h0000_0014, 32'h0, 1'b0, 4'hF, 32'h0506_0708, 1'b1);
    sample();
    checks++;
    if ({bus.wb_cyc_o, stallreq} !== 2'b01) begin
      errors++;
      $display("FAIL bb_gap: got cyc=%b stallreq=%b expected 0 1", bus.wb_cyc_o, stallreq);
    end
    next_cycle();
    bus.wb_ack_i = 1'b1; bus.wb_data_i = 32'h0506_0708;
    sample();
    checks++;
    if ({bus.wb_cyc_o, bus.wb_addr_o} !== {1'b1, 32'h0000_0014}) begin
      errors++;
      $display("FAIL bb_second: got cyc=%b addr=%h expected 1 00000014", bus.wb_cyc_o, bus.wb_addr_o);
    end
    next_cycle();
    bus.wb_ack_i = 1'b0; bus.wb_data_i = '0; cpu_ce_i = 1'b0;
    sample();
    checks++;
    if (bus.wb_cyc_o !== 1'b0) begin
      errors++;
      $display("FAIL bb_end: got cyc=%b expected 0", bus.wb_cyc_o);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached before completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_zero_wait_read();
    test_wait_write();
    test_stall_read();
    test_reset_in_busy();
    test_flush();
    test_back_to_back();
    next_cycle();
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL sb_drained: got %0d outstanding expected 0", sb_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
